// File: rtl/dmem_ram_pkg.sv
// Shared definitions for the data RAM: access-size codes, state encoding and
// the write-mask bundle passed from dmem_wmask to the top.
package dmem_ram_pkg;

  localparam logic [1:0] WA_BYTE = 2'd0;
  localparam logic [1:0] WA_HALF = 2'd1;
  localparam logic [1:0] WA_WORD = 2'd2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mis;
  } wmask_t;

endpackage

// File: rtl/dmem_wmask.sv
// Write lane decoder: access size + byte offset -> byte enables, lane-aligned
// write word and misalignment flag. Shared by the RAM and GPIO write paths.
module dmem_wmask
  import dmem_ram_pkg::*;
(
  input  logic [1:0]  wa_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output wmask_t      wm_o
);

  always_comb begin
    wm_o.be  = 4'b0000;
    wm_o.wd  = wdata_i << {off_i, 3'b000};
    wm_o.mis = 1'b0;
    case (wa_i)
      WA_BYTE: wm_o.be = 4'b0001 << off_i;
      WA_HALF: begin
        if (off_i[0]) wm_o.mis = 1'b1;
        else          wm_o.be  = 4'b0011 << off_i;
      end
      WA_WORD: begin
        if (off_i != 2'd0) wm_o.mis = 1'b1;
        else               wm_o.be  = 4'b1111;
      end
      default: wm_o.mis = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ram.sv
// Single-port data RAM with post-reset clear sequencer and combinational,
// offset-shifted reads. Define DMEM_MMIO_EN to add the memory-mapped GPIO register.
module dmem_ram
  import dmem_ram_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [1:0]  wa_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
`ifdef DMEM_MMIO_EN
  output logic [31:0] gpio_o,
`endif
  output logic        misalign_o
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          mis_q, mis_d;
  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          mmio_sel;
  wmask_t        wm;
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wd;
  logic [31:0]   rd_word;
  logic          unused_bits;

  // Upper address bits alias into the array.
  assign idx         = addr_i[AW+1:2];
  assign off         = addr_i[1:0];
  assign unused_bits = ^{addr_i[31:AW+2], MMIO_ADDR};

`ifdef DMEM_MMIO_EN
  logic [31:0] gpio_q, gpio_d;
  assign mmio_sel = (addr_i[31:2] == MMIO_ADDR[31:2]);
  assign gpio_o   = gpio_q;
`else
  assign mmio_sel = 1'b0;
`endif

  dmem_wmask u_wmask (
    .wa_i    (wa_i),
    .off_i   (off),
    .wdata_i (wdata_i),
    .wm_o    (wm)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    mem_we  = 1'b0;
    mem_idx = idx;
    mem_be  = wm.be;
    mem_wd  = wm.wd;
`ifdef DMEM_MMIO_EN
    gpio_d  = gpio_q;
`endif
    if (mmio_sel) begin
`ifdef DMEM_MMIO_EN
      // GPIO accepts writes in either state.
      if (we_i) begin
        if (wm.mis) mis_d = 1'b1;
        else
          for (int b = 0; b < 4; b++)
            if (wm.be[b]) gpio_d[8*b +: 8] = wm.wd[8*b +: 8];
      end
`endif
    end else if (state_q == ST_RUN && we_i) begin
      if (wm.mis) mis_d  = 1'b1;
      else        mem_we = 1'b1;
    end
    // Clear sequencer owns the port; user RAM writes are dropped silently.
    if (state_q == ST_CLEAR) begin
      mem_we  = 1'b1;
      mem_idx = cnt_q;
      mem_be  = 4'b1111;
      mem_wd  = 32'd0;
      cnt_d   = cnt_q + AW'(1);
      if (cnt_q == LAST) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
`ifdef DMEM_MMIO_EN
      gpio_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
`ifdef DMEM_MMIO_EN
      gpio_q  <= gpio_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
  end

  always_comb begin
`ifdef DMEM_MMIO_EN
    if (mmio_sel)                rd_word = gpio_q;
    else if (state_q == ST_RUN)  rd_word = mem_q[idx];
    else                         rd_word = 32'd0;
`else
    rd_word = (state_q == ST_RUN) ? mem_q[idx] : 32'd0;
`endif
  end

  assign rdata_o    = rd_word >> {off, 3'b000};
  assign ready_o    = (state_q == ST_RUN);
  assign misalign_o = mis_q;

endmodule

// File: tb/tb_dmem_ram.sv
// Directed bench for dmem_ram at DEPTH=16: clear timing, lane writes/reads,
// misalignment and mid-run reset; GPIO path when DMEM_MMIO_EN is defined.
module tb_dmem_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        we_i = 1'b0;
  logic [1:0]  wa_i = 2'd0;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        misalign_o;
`ifdef DMEM_MMIO_EN
  logic [31:0] gpio_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dmem_ram #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .we_i       (we_i),
    .wa_i       (wa_i),
    .rdata_o    (rdata_o),
    .ready_o    (ready_o),
`ifdef DMEM_MMIO_EN
    .gpio_o     (gpio_o),
`endif
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
    addr_i = a;
    #1;
    n_tests++;
    if (rdata_o !== exp) begin
      n_fail++;
      $display("FAIL %s: addr %h rdata %h expected %h", nm, a, rdata_o, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] wa);
    addr_i = a; wdata_i = d; wa_i = wa; we_i = 1'b1;
    tick;
    we_i = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_tests++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    n_tests++;
    if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign_o); end
    n_tests++;
    if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
`ifdef DMEM_MMIO_EN
    n_tests++;
    if (gpio_o !== 32'd0) begin n_fail++; $display("FAIL reset_gpio: got %h expected 0", gpio_o); end
`endif
  endtask

  // Release reset and walk the 16 clear cycles; optional dropped writes during clear.
  task automatic release_and_clear(input bit poke);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      we_i    = poke && (i == 5 || i == 6);
      addr_i  = 32'h0;
      wdata_i = 32'hFFFF_FFFF;
      wa_i    = (i == 6) ? 2'd3 : 2'd2;
      tick;
      n_tests++;
      if (ready_o !== (i == 16)) begin
        n_fail++;
        $display("FAIL clear_ready cycle %0d: got %b expected %b", i, ready_o, (i == 16));
      end
      n_tests++;
      if (misalign_o !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_misalign cycle %0d: got %b expected 0", i, misalign_o);
      end
    end
    we_i = 1'b0;
  endtask

  task automatic test_clear;
    release_and_clear(1'b0);
    for (int i = 0; i < 16; i++) rd_chk(32'(i * 4), 32'd0, "clear_zero");
  endtask

  task automatic test_word;
    addr_i = 32'h8; wdata_i = 32'hDEAD_BEEF; wa_i = 2'd2; we_i = 1'b1;
    #1;
    n_tests++;
    if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL same_cycle_old: got %h expected 0", rdata_o); end
    tick;
    we_i = 1'b0;
    n_tests++;
    if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL good_write_misalign: got %b expected 0", misalign_o); end
    rd_chk(32'h8, 32'hDEAD_BEEF, "word_rd");
    rd_chk(32'hB, 32'h0000_00DE, "word_rd_off3");
    rd_chk(32'h9, 32'h00DE_ADBE, "word_rd_off1");
    rd_chk(32'h48, 32'hDEAD_BEEF, "alias_rd");
  endtask

  task automatic test_byte_half;
    wr(32'h8, 32'h0, 2'd2);
    wr(32'h9, 32'hFFFF_FF55, 2'd0);
    rd_chk(32'h8, 32'h0000_5500, "byte_rd");
    wr(32'hA, 32'hFFFF_AABB, 2'd1);
    rd_chk(32'h8, 32'hAABB_5500, "byte_half_rd");
    rd_chk(32'hA, 32'h0000_AABB, "half_rd_off2");
  endtask

  task automatic test_misalign;
    logic [31:0] a [3];
    logic [1:0]  w [3];
    logic [31:0] e [3];
    a = '{32'h5, 32'h6, 32'h8};
    w = '{2'd1, 2'd2, 2'd3};
    e = '{32'h0, 32'h0, 32'hAABB_5500};
    for (int k = 0; k < 3; k++) begin
      wr(a[k], 32'h1111_1111, w[k]);
      n_tests++;
      if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_pulse %0d: got %b expected 1", k, misalign_o); end
      tick;
      n_tests++;
      if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_drop %0d: got %b expected 0", k, misalign_o); end
      rd_chk({a[k][31:2], 2'b00}, e[k], "mis_mem_unchanged");
    end
  endtask

  task automatic test_reset_midrun;
    wr(32'h4, 32'h1234_5678, 2'd2);
    rd_chk(32'h4, 32'h1234_5678, "pre_reset_rd");
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b expected 0", ready_o); end
    rd_chk(32'h4, 32'h0, "reset_rdata");
    release_and_clear(1'b1);
    rd_chk(32'h4, 32'h0, "post_reset_rd");
    rd_chk(32'h0, 32'h0, "clear_write_dropped");
    rd_chk(32'h8, 32'h0, "post_reset_rd8");
  endtask

`ifdef DMEM_MMIO_EN
  task automatic test_mmio;
    bit done = 1'b0;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    wr(32'h1000_0000, 32'hCAFE_F00D, 2'd2);
    n_tests++;
    if (gpio_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL gpio_wr: got %h expected cafef00d", gpio_o); end
    rd_chk(32'h1000_0002, 32'h0000_CAFE, "gpio_rd_off2");
    for (int i = 0; i < 40 && !done; i++) begin
      tick;
      done = ready_o;
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL gpio_clear_timeout: ready %b expected 1", ready_o); end
    rd_chk(32'h0, 32'h0, "gpio_ram_idx0");
  endtask
`endif

  initial begin
    test_reset;
    test_clear;
    test_word;
    test_byte_half;
    test_misalign;
    test_reset_midrun;
`ifdef DMEM_MMIO_EN
    test_mmio;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
